// File: rtl/serdes_rx_link_ctrl.sv
// serdes_rx_link_ctrl
// Link-level controller for the 8B/10B receive path: waits for bit alignment,
// hunts for a run of K28.5 commas, declares link-up and forwards data
// characters, and forces a timed resync on errors, alignment loss or timeout.
// Optional feature macro: SERDES_RX_ERR_CNT_EN builds the cumulative error
// counter on err_cnt; without it err_cnt is tied to zero.

module serdes_rx_link_ctrl #(
    parameter int COMMA_CNT     = 4,
    parameter int ERR_THRESH    = 4,
    parameter int ALIGN_TIMEOUT = 1024,
    parameter int RESYNC_CYC    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        link_en,
    input  logic        bit_align_done,
    input  logic        k_char,
    input  logic [7:0]  rx_data,
    input  logic        error,
    output logic        rx_enable,
    output logic        link_up,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        resync,
    output logic [2:0]  state,
    output logic [15:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_ALIGN = 3'd1,
        COMMA_HUNT = 3'd2,
        LINK_UP    = 3'd3,
        RESYNC     = 3'd4
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(ALIGN_TIMEOUT - 1);
    localparam logic [3:0]  COMMA_LAST = 4'(COMMA_CNT - 1);
    localparam logic [3:0]  ERR_LAST   = 4'(ERR_THRESH - 1);
    localparam logic [7:0]  HOLD_LAST  = 8'(RESYNC_CYC - 1);

    state_t      cur_state;
    state_t      next_state;
    logic [15:0] timer;
    logic [3:0]  comma_cnt;
    logic [3:0]  bad_cnt;
    logic [7:0]  hold_cnt;
    logic        is_comma;
    logic        timeout;
    logic        forward;

    assign is_comma = k_char && (rx_data == 8'hBC) && !error;
    assign timeout  = (timer == TIMER_LAST);
    assign state    = cur_state;

    // Next-state selection; a disable wins everywhere except inside RESYNC, and a timeout beats any success transition
    always_comb begin
        next_state = cur_state;
        forward    = 1'b0;
        case (cur_state)
            IDLE: begin
                if (link_en) next_state = WAIT_ALIGN;
            end
            WAIT_ALIGN: begin
                if (!link_en)            next_state = IDLE;
                else if (timeout)        next_state = RESYNC;
                else if (bit_align_done) next_state = COMMA_HUNT;
            end
            COMMA_HUNT: begin
                if (!link_en)                                next_state = IDLE;
                else if (timeout)                            next_state = RESYNC;
                else if (!bit_align_done)                    next_state = RESYNC;
                else if (is_comma && comma_cnt == COMMA_LAST) next_state = LINK_UP;
            end
            LINK_UP: begin
                if (!link_en)                            next_state = IDLE;
                else if (!bit_align_done)                next_state = RESYNC;
                else if (error && bad_cnt == ERR_LAST)   next_state = RESYNC;
            end
            RESYNC: begin
                if (hold_cnt == HOLD_LAST) next_state = link_en ? WAIT_ALIGN : IDLE;
            end
            default: next_state = IDLE;
        endcase
        forward = (cur_state == LINK_UP) && !k_char && !error && (next_state != RESYNC);
    end

    // State register and registered outputs, all derived from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= IDLE;
            rx_enable  <= 1'b0;
            link_up    <= 1'b0;
            resync     <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= 8'h00;
        end else begin
            cur_state  <= next_state;
            rx_enable  <= (next_state == WAIT_ALIGN) || (next_state == COMMA_HUNT) ||
                          (next_state == LINK_UP);
            link_up    <= (next_state == LINK_UP);
            resync     <= (next_state == RESYNC) && (cur_state != RESYNC);
            data_valid <= forward;
            if (forward) data_out <= rx_data;
        end
    end

    // Per-state saturating counters; each is held at zero outside the state that uses it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= 16'h0000;
            comma_cnt <= 4'h0;
            bad_cnt   <= 4'h0;
            hold_cnt  <= 8'h00;
        end else begin
            if (cur_state == WAIT_ALIGN || cur_state == COMMA_HUNT) begin
                if (timer != 16'hFFFF) timer <= timer + 16'h0001;
            end else begin
                timer <= 16'h0000;
            end

            if (cur_state == COMMA_HUNT && is_comma) begin
                if (comma_cnt != 4'hF) comma_cnt <= comma_cnt + 4'h1;
            end else begin
                comma_cnt <= 4'h0;
            end

            if (cur_state == LINK_UP && error) begin
                if (bad_cnt != 4'hF) bad_cnt <= bad_cnt + 4'h1;
            end else begin
                bad_cnt <= 4'h0;
            end

            if (cur_state == RESYNC) begin
                if (hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'h01;
            end else begin
                hold_cnt <= 8'h00;
            end
        end
    end

`ifdef SERDES_RX_ERR_CNT_EN
    // Cumulative error count over every enabled cycle, saturating, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 16'h0000;
        end else if (rx_enable && error && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'h0001;
        end
    end
`else
    assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_serdes_rx_link_ctrl.sv
// Testbench for serdes_rx_link_ctrl: table of directed vectors, hand-written
// timeout / async-reset / error-counter sequences, then random stimulus
// compared against a behavioural model of the link rules.

module tb_serdes_rx_link_ctrl;

    localparam int COMMA_CNT     = 4;
    localparam int ERR_THRESH    = 4;
    localparam int ALIGN_TIMEOUT = 1024;
    localparam int RESYNC_CYC    = 8;

    logic        clk;
    logic        rst_n;
    logic        link_en;
    logic        bit_align_done;
    logic        k_char;
    logic [7:0]  rx_data;
    logic        error;
    logic        rx_enable;
    logic        link_up;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        resync;
    logic [2:0]  state;
    logic [15:0] err_cnt;

    int total_cnt = 0;
    int bad_cnt   = 0;

    serdes_rx_link_ctrl #(
        .COMMA_CNT    (COMMA_CNT),
        .ERR_THRESH   (ERR_THRESH),
        .ALIGN_TIMEOUT(ALIGN_TIMEOUT),
        .RESYNC_CYC   (RESYNC_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .link_en       (link_en),
        .bit_align_done(bit_align_done),
        .k_char        (k_char),
        .rx_data       (rx_data),
        .error         (error),
        .rx_enable     (rx_enable),
        .link_up       (link_up),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .resync        (resync),
        .state         (state),
        .err_cnt       (err_cnt)
    );

    // Free-running character clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: run lengths and a countdown, following the link rules directly
    int          m_state;
    bit          m_enable, m_up, m_valid, m_resync;
    logic [7:0]  m_data;
    int          m_err, m_since, m_commas, m_bad, m_hold;

    task automatic modelReset();
        m_state = 0; m_enable = 0; m_up = 0; m_valid = 0; m_resync = 0;
        m_data = 8'h00; m_err = 0; m_since = 0; m_commas = 0; m_bad = 0; m_hold = 0;
    endtask

    task automatic modelStep(input logic le, input logic al, input logic k,
                             input logic [7:0] d, input logic e);
        int nxt;
        bit comma;
        bit fwd;
        comma = k && (d == 8'hBC) && !e;
`ifdef SERDES_RX_ERR_CNT_EN
        if (m_enable && e && m_err < 65535) m_err++;
`endif
        nxt = m_state;
        case (m_state)
            0: if (le) begin nxt = 1; m_since = 0; end
            1, 2: begin
                if (!le) nxt = 0;
                else if (m_since >= ALIGN_TIMEOUT - 1) nxt = 4;
                else if (m_state == 1) begin
                    if (al) begin nxt = 2; m_commas = 0; end
                end else if (!al) nxt = 4;
                else begin
                    m_commas = comma ? m_commas + 1 : 0;
                    if (m_commas >= COMMA_CNT) begin nxt = 3; m_bad = 0; end
                end
                m_since++;
            end
            3: begin
                if (!le) nxt = 0;
                else if (!al) nxt = 4;
                else begin
                    m_bad = e ? m_bad + 1 : 0;
                    if (m_bad >= ERR_THRESH) nxt = 4;
                end
            end
            default: begin
                m_hold--;
                if (m_hold <= 0) begin
                    nxt = le ? 1 : 0;
                    m_since = 0;
                end
            end
        endcase
        if (nxt == 4 && m_state != 4) m_hold = RESYNC_CYC;
        fwd      = (m_state == 3) && !k && !e && (nxt != 4);
        m_valid  = fwd;
        if (fwd) m_data = d;
        m_resync = (nxt == 4) && (m_state != 4);
        m_enable = (nxt >= 1) && (nxt <= 3);
        m_up     = (nxt == 3);
        m_state  = nxt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic le, input logic al, input logic k,
                                 input logic [7:0] d, input logic e);
        link_en = le; bit_align_done = al; k_char = k; rx_data = d; error = e;
        @(posedge clk);
        #1;
        modelStep(le, al, k, d, e);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        link_en = 0; bit_align_done = 0; k_char = 0; rx_data = 8'h00; error = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    function automatic logic [31:0] dutAll();
        return {1'b0, state, rx_enable, link_up, data_valid, data_out, resync, err_cnt};
    endfunction

    function automatic logic [31:0] modelAll();
        return {1'b0, 3'(m_state), m_enable, m_up, m_valid, m_data, m_resync, 16'(m_err)};
    endfunction

    typedef struct {
        logic       le, al, k;
        logic [7:0] d;
        logic       e;
        logic [2:0] st;
        logic       en, up, vld;
        logic [7:0] dout;
        logic       rs;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic le, al, k, input logic [7:0] d, input logic e,
                          input logic [2:0] st, input logic en, up, vld,
                          input logic [7:0] dout, input logic rs);
        vec_t v;
        v.le = le; v.al = al; v.k = k; v.d = d; v.e = e;
        v.st = st; v.en = en; v.up = up; v.vld = vld; v.dout = dout; v.rs = rs;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        int ones;
        logic [15:0] exp_err5;

        // Directed vectors: bring-up, error threshold, broken comma run, alignment loss, disable
        for (int i = 0; i < 4; i++) addVec(1, 0, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00, 0);
        addVec(1, 1, 0, 8'h00, 0, 2, 1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) addVec(1, 1, 1, 8'hBC, 0, 2, 1, 0, 0, 8'h00, 0);
        addVec(1, 1, 1, 8'hBC, 0, 3, 1, 1, 0, 8'h00, 0);
        addVec(1, 1, 0, 8'h12, 0, 3, 1, 1, 1, 8'h12, 0);
        addVec(1, 1, 0, 8'h34, 0, 3, 1, 1, 1, 8'h34, 0);
        addVec(1, 1, 1, 8'hBC, 0, 3, 1, 1, 0, 8'h34, 0);
        for (int i = 0; i < 3; i++) addVec(1, 1, 0, 8'h55, 1, 3, 1, 1, 0, 8'h34, 0);
        addVec(1, 1, 0, 8'h66, 0, 3, 1, 1, 1, 8'h66, 0);
        for (int i = 0; i < 3; i++) addVec(1, 1, 0, 8'h55, 1, 3, 1, 1, 0, 8'h66, 0);
        addVec(1, 1, 0, 8'h55, 1, 4, 0, 0, 0, 8'h66, 1);
        for (int i = 0; i < 7; i++) addVec(1, 0, 0, 8'h00, 0, 4, 0, 0, 0, 8'h66, 0);
        addVec(1, 0, 0, 8'h00, 0, 1, 1, 0, 0, 8'h66, 0);
        addVec(1, 1, 0, 8'h00, 0, 2, 1, 0, 0, 8'h66, 0);
        for (int i = 0; i < 2; i++) addVec(1, 1, 1, 8'hBC, 0, 2, 1, 0, 0, 8'h66, 0);
        addVec(1, 1, 0, 8'h77, 0, 2, 1, 0, 0, 8'h66, 0);
        for (int i = 0; i < 3; i++) addVec(1, 1, 1, 8'hBC, 0, 2, 1, 0, 0, 8'h66, 0);
        addVec(1, 1, 1, 8'hBC, 0, 3, 1, 1, 0, 8'h66, 0);
        addVec(1, 0, 0, 8'h55, 1, 4, 0, 0, 0, 8'h66, 1);
        for (int i = 0; i < 7; i++) addVec(0, 0, 0, 8'h00, 0, 4, 0, 0, 0, 8'h66, 0);
        addVec(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h66, 0);
        addVec(1, 0, 0, 8'h00, 0, 1, 1, 0, 0, 8'h66, 0);
        addVec(1, 1, 0, 8'h00, 0, 2, 1, 0, 0, 8'h66, 0);
        for (int i = 0; i < 3; i++) addVec(1, 1, 1, 8'hBC, 0, 2, 1, 0, 0, 8'h66, 0);
        addVec(1, 1, 1, 8'hBC, 0, 3, 1, 1, 0, 8'h66, 0);
        addVec(1, 1, 0, 8'hA5, 0, 3, 1, 1, 1, 8'hA5, 0);
        addVec(1, 0, 0, 8'h99, 0, 4, 0, 0, 0, 8'hA5, 1);
        for (int i = 0; i < 7; i++) addVec(1, 1, 0, 8'h00, 0, 4, 0, 0, 0, 8'hA5, 0);
        addVec(1, 1, 0, 8'h00, 0, 1, 1, 0, 0, 8'hA5, 0);
        addVec(1, 1, 0, 8'h00, 0, 2, 1, 0, 0, 8'hA5, 0);
        for (int i = 0; i < 3; i++) addVec(1, 1, 1, 8'hBC, 0, 2, 1, 0, 0, 8'hA5, 0);
        addVec(1, 1, 1, 8'hBC, 0, 3, 1, 1, 0, 8'hA5, 0);
        addVec(0, 1, 1, 8'hBC, 0, 0, 0, 0, 0, 8'hA5, 0);

        // Reset values while rst_n is held low
        rst_n = 1'b0;
        link_en = 0; bit_align_done = 0; k_char = 0; rx_data = 8'h00; error = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_flags", {28'h0, rx_enable, link_up, data_valid, resync}, 32'h0);
        checkOutput("reset_data", 32'(data_out), 32'h00);
        checkOutput("reset_err", 32'(err_cnt), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].le, vecs[i].al, vecs[i].k, vecs[i].d, vecs[i].e);
            checkOutput($sformatf("vec%0d", i),
                        {17'h0, state, rx_enable, link_up, data_valid, data_out, resync},
                        {17'h0, vecs[i].st, vecs[i].en, vecs[i].up, vecs[i].vld, vecs[i].dout, vecs[i].rs});
        end
        checkOutput("vec_err_cnt", 32'(err_cnt), 32'(m_err));

        // Alignment timeout: RESYNC exactly ALIGN_TIMEOUT edges after WAIT_ALIGN entry
        applyStimulus(1, 0, 0, 8'h00, 0);
        n = 0;
        do begin
            applyStimulus(1, 0, 0, 8'h00, 0);
            n++;
        end while (state != 3'd4 && n < 2000);
        checkOutput("timeout_cycles", 32'(n), 32'd1024);
        checkOutput("timeout_resync", {31'h0, resync}, 32'h1);
        repeat (RESYNC_CYC) applyStimulus(1, 0, 0, 8'h00, 0);
        checkOutput("timeout_rewait", 32'(state), 32'd1);

        // Bring the link up again and forward one character, then reset asynchronously
        applyStimulus(1, 1, 0, 8'h00, 0);
        repeat (COMMA_CNT) applyStimulus(1, 1, 1, 8'hBC, 0);
        applyStimulus(1, 1, 0, 8'hC3, 0);
        checkOutput("pre_reset_link", {24'h0, link_up, data_valid, data_out[5:0]}, {24'h0, 1'b1, 1'b1, 6'h03});
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_all", {16'h0, state, rx_enable, link_up, data_valid, data_out, resync}, 32'h0);
        checkOutput("async_reset_err", 32'(err_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();

        // Error counter: five enabled error cycles
        applyStimulus(1, 0, 0, 8'h00, 0);
        repeat (5) applyStimulus(1, 0, 0, 8'h00, 1);
`ifdef SERDES_RX_ERR_CNT_EN
        exp_err5 = 16'd5;
`else
        exp_err5 = 16'd0;
`endif
        checkOutput("err_cnt_five", 32'(err_cnt), 32'(exp_err5));
`ifdef SERDES_RX_ERR_CNT_EN
        repeat (66500) applyStimulus(1, 0, 0, 8'h00, 1);
        checkOutput("err_cnt_sat", 32'(err_cnt), 32'hFFFF);
`endif

        // Random stimulus against the behavioural model
        doReset();
        for (int i = 0; i < 3000; i++) begin
            logic le, al, k, e;
            logic [7:0] d;
            le = ($urandom_range(99) != 0);
            al = ($urandom_range(49) != 0);
            e  = ($urandom_range(99) < 15);
            if ($urandom_range(1) == 1) begin
                k = 1'b1; d = 8'hBC;
            end else begin
                k = ($urandom_range(4) == 0);
                d = 8'($urandom);
            end
            applyStimulus(le, al, k, d, e);
            checkOutput($sformatf("rand%0d", i), dutAll(), modelAll());
        end

        ones = 0;
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
